mem_access_requester: RTL and testbench

- Processor-side initiator for the 20-bit byte-addressed memory controller.
- Accepts one RISC-V load/store at a time from the pipeline and translates funct3 into controller operation codes.
- Handshakes on the controller's status line and returns the sign/zero-extended load result or a completion.
- Synthesises SB/SH/SW as read-modify-write, because the controller only writes full 64-bit doublewords.

---
 rtl/mem_ctrl_pkg.sv | 45 ++++
 rtl/load_extend.sv | 26 ++
 rtl/mem_access_requester.sv | 150 +++++++++++++++
 tb/tb_mem_access_requester.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the processor-side requester and the 20-bit memory controller:
// operation codes, RISC-V load/store funct3 values, requester FSM encoding and byte-lane masks.
package mem_ctrl_pkg;

    localparam int DATA_W = 64;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_READ_D = 3'b001;
    localparam logic [2:0] OP_READ_W = 3'b010;
    localparam logic [2:0] OP_READ_H = 3'b011;
    localparam logic [2:0] OP_READ_B = 3'b100;
    localparam logic [2:0] OP_WRITE  = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_MERGE,
        ST_RESP
    } state_t;

    // funct3[1:0] encodes the access size for both loads and stores: 1/2/4/8 bytes.
    function automatic logic [DATA_W-1:0] byte_mask(input logic [1:0] size);
        case (size)
            2'b00:   byte_mask = 64'h0000_0000_0000_00FF;
            2'b01:   byte_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   byte_mask = 64'h0000_0000_FFFF_FFFF;
            default: byte_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load result formatter: keeps the low 1/2/4/8 bytes of the controller data and
// sign- or zero-extends them according to the load funct3.
module load_extend
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] ext
);

    logic [DATA_W-1:0] mask;
    logic              sign;

    always_comb begin
        mask = byte_mask(funct3[1:0]);
        sign = 1'b0;
        case (funct3)
            F3_LB:   sign = raw[7];
            F3_LH:   sign = raw[15];
            F3_LW:   sign = raw[31];
            default: sign = 1'b0;
        endcase
        ext = sign ? ((raw & mask) | ~mask) : (raw & mask);
    end

endmodule

// File: rtl/mem_access_requester.sv
// Processor-side initiator for the byte-addressed memory controller: one load/store at a time,
// sub-doubleword stores done as read-modify-write, with a per-phase timeout.
module mem_access_requester
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    output logic [63:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mc_address,
    output logic [2:0]        mc_operation,
    output logic [63:0]       mc_write_data,
    input  logic              mc_status,
    input  logic [63:0]       mc_data
);

    localparam int              CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state, state_nx;
    logic                is_store_r;
    logic                rmw_r;
    logic [2:0]          funct3_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [63:0]         wdata_r;
    logic [63:0]         wr_data_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                hs;
    logic                illegal;
    logic                err_nx;
    logic [63:0]         ext_data;
    logic [63:0]         merged;

    function automatic logic [2:0] issue_op(input logic store, input logic rmw,
                                            input logic [1:0] size);
        if (store) begin
            issue_op = rmw ? OP_READ_D : OP_WRITE;
        end else begin
            case (size)
                2'b00:   issue_op = OP_READ_B;
                2'b01:   issue_op = OP_READ_H;
                2'b10:   issue_op = OP_READ_W;
                default: issue_op = OP_READ_D;
            endcase
        end
    endfunction

    assign req_ready     = (state == ST_IDLE);
    assign hs            = req_valid && req_ready;
    assign illegal       = req_is_store ? req_funct3[2] : (req_funct3 == 3'b111);
    assign mc_address    = addr_r;
    assign mc_write_data = wr_data_r;
    assign merged        = (mc_data & ~byte_mask(funct3_r[1:0]))
                         | (wdata_r & byte_mask(funct3_r[1:0]));

    load_extend u_load_extend (
        .funct3 (funct3_r),
        .raw    (mc_data),
        .ext    (ext_data)
    );

    always_comb begin
        state_nx     = state;
        err_nx       = 1'b0;
        mc_operation = OP_NOP;
        unique case (state)
            ST_IDLE: begin
                if (hs) begin
                    state_nx = illegal ? ST_RESP : ST_ISSUE;
                    err_nx   = illegal;
                end
            end
            ST_ISSUE: begin
                mc_operation = issue_op(is_store_r, rmw_r, funct3_r[1:0]);
                if (mc_status) begin
                    state_nx = ST_WAIT_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx = ST_RESP;
                    err_nx   = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!mc_status) begin
                    state_nx = (is_store_r && rmw_r) ? ST_MERGE : ST_RESP;
                end else if (cnt_r == CNT_LAST) begin
                    state_nx = ST_RESP;
                    err_nx   = 1'b1;
                end
            end
            ST_MERGE: state_nx = ST_ISSUE;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt_r      <= '0;
            is_store_r <= 1'b0;
            rmw_r      <= 1'b0;
            funct3_r   <= '0;
            addr_r     <= '0;
            wdata_r    <= '0;
            wr_data_r  <= '0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_nx;
            // Timer restarts on every state entry so each wait phase gets the full budget.
            if (state_nx != state) begin
                cnt_r <= '0;
            end else if (state == ST_ISSUE || state == ST_WAIT_DONE) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end

            if (hs) begin
                is_store_r <= req_is_store;
                rmw_r      <= req_is_store && (req_funct3[1:0] != 2'b11);
                funct3_r   <= req_funct3;
                addr_r     <= req_addr;
                wdata_r    <= req_wdata;
                wr_data_r  <= req_wdata;
            end

            if (state == ST_MERGE) begin
                wr_data_r <= merged;
                rmw_r     <= 1'b0;
            end

            // Response registers follow the RESP state exactly; load data is captured on WAIT_DONE exit.
            resp_valid <= (state_nx == ST_RESP);
            resp_error <= (state_nx == ST_RESP) && err_nx;
            resp_rdata <= ((state == ST_WAIT_DONE) && (state_nx == ST_RESP) && !err_nx && !is_store_r)
                        ? ext_data : '0;
        end
    end

endmodule

// File: tb/tb_mem_access_requester.sv
// Directed + randomized bench for mem_access_requester with a behavioural memory controller
// and an independent byte-level reference memory.
module tb_mem_access_requester;

    localparam int TIMEOUT = 64;
    localparam logic [2:0] C_NOP = 3'b000, C_RD_D = 3'b001, C_RD_W = 3'b010,
                           C_RD_H = 3'b011, C_RD_B = 3'b100, C_WR = 3'b111;

    logic        clk, reset;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [19:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_error;
    logic [63:0] resp_rdata;
    logic [19:0] mc_address;
    logic [2:0]  mc_operation;
    logic [63:0] mc_write_data;
    logic        mc_status;
    logic [63:0] mc_data;

    int total = 0;
    int bad   = 0;

    mem_access_requester #(.ADDR_W(20), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mc_address(mc_address), .mc_operation(mc_operation), .mc_write_data(mc_write_data),
        .mc_status(mc_status), .mc_data(mc_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    bit [7:0] ctl_mem [int];
    bit [7:0] ref_mem [int];

    function automatic bit [7:0] rd_ctl(input logic [19:0] a);
        return ctl_mem.exists(int'(a)) ? ctl_mem[int'(a)] : 8'h00;
    endfunction

    function automatic bit [7:0] rd_ref(input logic [19:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int op_bytes(input logic [2:0] op);
        case (op)
            C_RD_B:  return 1;
            C_RD_H:  return 2;
            C_RD_W:  return 4;
            default: return 8;
        endcase
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [19:0] a);
        int n = nbytes(f3);
        logic [63:0] v = 64'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = rd_ref(a + 20'(k));
        if (f3 < 3'd3 && n < 8 && v[8*n-1]) v = v | ({64{1'b1}} << (8*n));
        return v;
    endfunction

    function automatic logic [2:0] ref_load_op(input logic [2:0] f3);
        case (nbytes(f3))
            1:       return C_RD_B;
            2:       return C_RD_H;
            4:       return C_RD_W;
            default: return C_RD_D;
        endcase
    endfunction

    // Behavioural controller: accepts an operation, stays busy a few cycles, then completes.
    int          ctl_mode  = 0;   // 0 normal, 1 never answers, 2 busy forever
    int          busy_min  = 1;
    int          busy_max  = 3;
    int          busy_left = 0;
    logic [2:0]  cur_op;
    logic [19:0] cur_addr;
    logic [63:0] cur_wd;
    logic [2:0]  log_op   [$];
    logic [19:0] log_addr [$];
    logic [63:0] log_wd   [$];

    initial begin
        logic [63:0] d;
        mc_status = 1'b0;
        mc_data   = 64'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_left = 0;
                mc_status = 1'b0;
            end else if (busy_left > 0) begin
                if (ctl_mode != 2) busy_left--;
                if (busy_left == 0) begin
                    d = {$urandom, $urandom};
                    if (cur_op == C_WR) begin
                        for (int k = 0; k < 8; k++) ctl_mem[int'(cur_addr + 20'(k))] = cur_wd[8*k +: 8];
                    end else begin
                        for (int k = 0; k < op_bytes(cur_op); k++) d[8*k +: 8] = rd_ctl(cur_addr + 20'(k));
                    end
                    mc_data   = d;
                    mc_status = 1'b0;
                end
            end else if (ctl_mode != 1 && mc_operation != C_NOP) begin
                cur_op   = mc_operation;
                cur_addr = mc_address;
                cur_wd   = mc_write_data;
                log_op.push_back(cur_op);
                log_addr.push_back(cur_addr);
                log_wd.push_back(cur_wd);
                busy_left = $urandom_range(busy_min, busy_max);
                mc_status = 1'b1;
            end
        end
    end

    int resp_cnt = 0;
    always @(negedge clk) if (resp_valid) resp_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [19:0] a, input logic [7:0] b);
        ctl_mem[int'(a)] = b;
        ref_mem[int'(a)] = b;
    endtask

    // One request end to end; to_lat != 0 means a timeout is expected after that many cycles.
    task automatic run_req(input bit st, input logic [2:0] f3, input logic [19:0] a,
                           input logic [63:0] wd, input int to_lat, input string tag,
                           output logic [63:0] rd, output logic er, output int lat);
        int          nlog0 = log_op.size();
        int          nresp0 = resp_cnt;
        bit          ill = st ? f3[2] : (f3 == 3'b111);
        int          n = nbytes(f3);
        int          exp_n;
        logic [63:0] exp_rd, exp_wr;
        logic [2:0]  exp_ops [2];

        exp_rd = (!st && !ill && to_lat == 0) ? ref_load(f3, a) : 64'd0;
        for (int k = 0; k < 8; k++) exp_wr[8*k +: 8] = (k < n) ? wd[8*k +: 8] : rd_ref(a + 20'(k));
        exp_ops[0] = C_NOP;
        exp_ops[1] = C_NOP;
        if (ill) exp_n = 0;
        else if (!st) begin exp_n = 1; exp_ops[0] = ref_load_op(f3); end
        else if (n == 8) begin exp_n = 1; exp_ops[0] = C_WR; end
        else begin exp_n = 2; exp_ops[0] = C_RD_D; exp_ops[1] = C_WR; end

        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        chk({tag, " req_ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 3 * TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " resp_valid"}, resp_valid, 1);
        rd = resp_rdata;
        er = resp_error;
        chk({tag, " resp_error"}, er, (ill || to_lat != 0) ? 1 : 0);
        chk({tag, " resp_rdata"}, rd, exp_rd);
        if (to_lat != 0) chk({tag, " timeout latency"}, lat, to_lat);
        @(negedge clk);
        chk({tag, " resp pulses"}, resp_cnt - nresp0, 1);
        chk({tag, " ready after"}, req_ready, 1);
        if (to_lat == 0) begin
            chk({tag, " op count"}, log_op.size() - nlog0, exp_n);
            for (int i = 0; i < exp_n && nlog0 + i < log_op.size(); i++) begin
                chk({tag, " op"}, log_op[nlog0 + i], exp_ops[i]);
                chk({tag, " addr"}, log_addr[nlog0 + i], a);
                if (exp_ops[i] == C_WR) chk({tag, " write data"}, log_wd[nlog0 + i], exp_wr);
            end
            if (st && !ill) for (int k = 0; k < n; k++) ref_mem[int'(a + 20'(k))] = wd[8*k +: 8];
        end
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        int          nlog0, nresp0;
        bit          st;
        logic [2:0]  f3;
        logic [19:0] a;

        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 20'd0; req_wdata = 64'd0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", req_ready, 1);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset resp_rdata", resp_rdata, 0);
        chk("reset resp_error", resp_error, 0);
        chk("reset mc_operation", mc_operation, C_NOP);
        chk("reset mc_address", mc_address, 0);
        chk("reset mc_write_data", mc_write_data, 0);
        reset = 1'b0;
        @(negedge clk);

        // Byte loads, minimum latency with a one-cycle controller.
        busy_min = 1; busy_max = 1;
        poke(20'h00010, 8'h80);
        run_req(1'b0, 3'b000, 20'h00010, 64'd0, 0, "LB", rd, er, lat);
        chk("LB value", rd, 64'hFFFF_FFFF_FFFF_FF80);
        chk("LB min latency", lat, 2);
        busy_min = 1; busy_max = 3;
        run_req(1'b0, 3'b100, 20'h00010, 64'd0, 0, "LBU", rd, er, lat);
        chk("LBU value", rd, 64'h0000_0000_0000_0080);

        poke(20'h00100, 8'h78); poke(20'h00101, 8'h56); poke(20'h00102, 8'h34); poke(20'h00103, 8'hF2);
        poke(20'h00104, 8'hEE); poke(20'h00105, 8'hDD);
        run_req(1'b0, 3'b010, 20'h00100, 64'd0, 0, "LW", rd, er, lat);
        chk("LW value", rd, 64'hFFFF_FFFF_F234_5678);
        run_req(1'b0, 3'b110, 20'h00100, 64'd0, 0, "LWU", rd, er, lat);
        run_req(1'b0, 3'b001, 20'h00102, 64'd0, 0, "LH", rd, er, lat);
        chk("LH value", rd, 64'hFFFF_FFFF_FFFF_F234);

        run_req(1'b1, 3'b011, 20'h00200, 64'h1122_3344_5566_7788, 0, "SD", rd, er, lat);
        chk("SD rdata zero", rd, 64'd0);
        run_req(1'b0, 3'b011, 20'h00200, 64'd0, 0, "LD", rd, er, lat);
        chk("LD value", rd, 64'h1122_3344_5566_7788);

        run_req(1'b1, 3'b000, 20'h00200, 64'hFFFF_FFFF_FFFF_FFAB, 0, "SB", rd, er, lat);
        run_req(1'b0, 3'b011, 20'h00200, 64'd0, 0, "LD after SB", rd, er, lat);
        chk("LD after SB value", rd, 64'h1122_3344_5566_77AB);

        run_req(1'b0, 3'b111, 20'h00200, 64'd0, 0, "illegal load", rd, er, lat);
        chk("illegal load latency", lat, 0);
        run_req(1'b1, 3'b101, 20'h00200, 64'd5, 0, "illegal store", rd, er, lat);

        // Controller never raises busy: timeout while issuing.
        ctl_mode = 1;
        run_req(1'b0, 3'b011, 20'h00300, 64'd0, TIMEOUT, "timeout issue", rd, er, lat);
        chk("timeout issue op back to NOP", mc_operation, C_NOP);
        ctl_mode = 0;
        // Controller stays busy forever: timeout while waiting for done.
        ctl_mode = 2;
        run_req(1'b0, 3'b010, 20'h00300, 64'd0, TIMEOUT + 1, "timeout wait", rd, er, lat);
        ctl_mode = 0;
        repeat (busy_max + 3) @(negedge clk);

        // Reset while an SB read-modify-write waits on its READ_D.
        busy_min = 6; busy_max = 6;
        nlog0 = log_op.size();
        nresp0 = resp_cnt;
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 20'h00200; req_wdata = 64'hCD;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst-rmw read issued", log_op.size() - nlog0, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst-rmw req_ready", req_ready, 1);
        chk("rst-rmw mc_operation", mc_operation, C_NOP);
        chk("rst-rmw resp_valid", resp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst-rmw no write", log_op.size() - nlog0, 1);
        chk("rst-rmw no response", resp_cnt - nresp0, 0);
        busy_min = 1; busy_max = 3;
        run_req(1'b0, 3'b011, 20'h00200, 64'd0, 0, "LD after reset", rd, er, lat);
        chk("LD after reset value", rd, 64'h1122_3344_5566_77AB);

        // Random mix, including addresses that wrap past the top of the address space.
        for (int i = 0; i < 40; i++) begin
            st = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) f3 = st ? 3'(4 + $urandom_range(0, 3)) : 3'b111;
            else f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) a = 20'hFFFFC + 20'($urandom_range(0, 3));
            else a = 20'h00400 + 20'($urandom_range(0, 23));
            run_req(st, f3, a, {$urandom, $urandom}, 0, "random", rd, er, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
